// File: rtl/data_load_aligner.sv
// Load-path stage: checks alignment, issues a word read with a bounded handshake wait,
// and returns the addressed byte/halfword shifted to bit 0 as a one-cycle registered result.
module data_load_aligner #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        Inicio,
   input  logic [31:0] Direccion,
   input  logic [1:0]  Tamano,
   output logic        Ocupado,
   output logic        MemReq,
   output logic [31:0] MemAddr,
   input  logic        MemReady,
   input  logic [31:0] MemRData,
   output logic [31:0] Dato,
   output logic [7:0]  Byte,
   output logic        Valido,
   output logic        Error
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CHECK = 3'd1,
      S_REQ   = 3'd2,
      S_DONE  = 3'd3,
      S_FAIL  = 3'd4
   } state_e;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_e            state_q, state_d;
   logic [31:0]       dir_q, dir_d;
   logic [1:0]        tam_q, tam_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              req_q, req_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       dato_q, dato_d;
   logic              valido_q, valido_d;
   logic              error_q, error_d;
   logic              ocupado_q, ocupado_d;

   function automatic logic access_illegal(input logic [1:0] off, input logic [1:0] sz);
      logic bad;
      case (sz)
         2'b00:   bad = 1'b0;
         2'b01:   bad = off[0];
         2'b10:   bad = (off != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   function automatic logic [31:0] align_load(input logic [31:0] w, input logic [1:0] off,
                                              input logic [1:0] sz);
      logic [31:0] r;
      case (sz)
         2'b00: begin
            case (off)
               2'b00:   r = {24'h000000, w[7:0]};
               2'b01:   r = {24'h000000, w[15:8]};
               2'b10:   r = {24'h000000, w[23:16]};
               default: r = {24'h000000, w[31:24]};
            endcase
         end
         2'b01: begin
            if (off[1]) begin
               r = {16'h0000, w[31:16]};
            end else begin
               r = {16'h0000, w[15:0]};
            end
         end
         default: r = w;
      endcase
      return r;
   endfunction

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         dir_q     <= 32'h0000_0000;
         tam_q     <= 2'b00;
         cnt_q     <= '0;
         req_q     <= 1'b0;
         addr_q    <= 32'h0000_0000;
         dato_q    <= 32'h0000_0000;
         valido_q  <= 1'b0;
         error_q   <= 1'b0;
         ocupado_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         dir_q     <= dir_d;
         tam_q     <= tam_d;
         cnt_q     <= cnt_d;
         req_q     <= req_d;
         addr_q    <= addr_d;
         dato_q    <= dato_d;
         valido_q  <= valido_d;
         error_q   <= error_d;
         ocupado_q <= ocupado_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d  = state_q;
      dir_d    = dir_q;
      tam_d    = tam_q;
      cnt_d    = cnt_q;
      req_d    = req_q;
      addr_d   = addr_q;
      dato_d   = dato_q;
      valido_d = 1'b0;
      error_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (Inicio) begin
               dir_d   = Direccion;
               tam_d   = Tamano;
               state_d = S_CHECK;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CHECK: begin
            if (access_illegal(dir_q[1:0], tam_q)) begin
               error_d = 1'b1;
               state_d = S_FAIL;
            end else begin
               req_d   = 1'b1;
               addr_d  = {dir_q[31:2], 2'b00};
               cnt_d   = '0;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            // A ready on the last counted cycle still completes the load.
            if (MemReady) begin
               dato_d   = align_load(MemRData, dir_q[1:0], tam_q);
               req_d    = 1'b0;
               valido_d = 1'b1;
               state_d  = S_DONE;
            end else if (cnt_q == CNT_LAST) begin
               req_d   = 1'b0;
               error_d = 1'b1;
               state_d = S_FAIL;
            end else begin
               cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_FAIL:  state_d = S_IDLE;
         default: begin
            req_d   = 1'b0;
            state_d = S_IDLE;
         end
      endcase
      ocupado_d = (state_d != S_IDLE);
   end

   assign Ocupado = ocupado_q;
   assign MemReq  = req_q;
   assign MemAddr = addr_q;
   assign Dato    = dato_q;
   assign Byte    = dato_q[7:0];
   assign Valido  = valido_q;
   assign Error   = error_q;

endmodule

// File: tb/tb_data_load_aligner.sv
// Directed bench for data_load_aligner: the stimulus pushes expected results into a
// scoreboard queue, and a monitor pops and compares on every Valido/Error pulse.
module tb_data_load_aligner;

   logic        clk;
   logic        rst;
   logic        Inicio;
   logic [31:0] Direccion;
   logic [1:0]  Tamano;
   logic        Ocupado;
   logic        MemReq;
   logic [31:0] MemAddr;
   logic        MemReady;
   logic [31:0] MemRData;
   logic [31:0] Dato;
   logic [7:0]  Byte;
   logic        Valido;
   logic        Error;

   typedef struct {
      logic        err;
      logic [31:0] dato;
   } exp_t;

   exp_t        sb_q[$];
   int          vectors     = 0;
   int          miscompares = 0;
   logic [31:0] last_dato   = 32'h0000_0000;

   data_load_aligner #(.TIMEOUT(16), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .Inicio(Inicio), .Direccion(Direccion), .Tamano(Tamano),
      .Ocupado(Ocupado), .MemReq(MemReq), .MemAddr(MemAddr), .MemReady(MemReady),
      .MemRData(MemRData), .Dato(Dato), .Byte(Byte), .Valido(Valido), .Error(Error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every Valido/Error pulse must match the oldest expected result.
   always @(negedge clk) begin
      if (!rst && (Valido || Error)) begin
         vectors++;
         if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_result: Valido=%0b Error=%0b Dato=0x%08h expected no result",
                     Valido, Error, Dato);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            if (Valido !== !e.err || Error !== e.err || Dato !== e.dato || Byte !== e.dato[7:0]) begin
               miscompares++;
               $display("FAIL result: Valido=%0b Error=%0b Dato=0x%08h Byte=0x%02h expected Error=%0b Dato=0x%08h Byte=0x%02h",
                        Valido, Error, Dato, Byte, e.err, e.dato, e.dato[7:0]);
            end
         end
      end
   end

   task automatic do_load(input logic [31:0] addr, input logic [1:0] tam, input int wait_n,
                          input logic [31:0] rdata, input logic exp_err,
                          input logic [31:0] exp_dato, input int exp_req, input logic inj);
      exp_t e;
      int   req_cycles;
      e.err  = exp_err;
      e.dato = exp_err ? last_dato : exp_dato;
      sb_q.push_back(e);
      if (!exp_err) last_dato = exp_dato;
      @(posedge clk); #1;
      Inicio    = 1'b1;
      Direccion = addr;
      Tamano    = tam;
      @(posedge clk); #1;
      Inicio    = 1'b0;
      Direccion = 32'hFFFF_FFFF;
      chk("check_busy", {31'd0, Ocupado}, 32'd1);
      chk("check_noreq", {31'd0, MemReq}, 32'd0);
      @(posedge clk); #1;
      req_cycles = 0;
      for (int c = 0; c < 64; c++) begin
         if (!MemReq) break;
         req_cycles++;
         if (MemAddr !== {addr[31:2], 2'b00}) chk("memaddr", MemAddr, {addr[31:2], 2'b00});
         if (c == wait_n) begin
            MemReady = 1'b1;
            MemRData = rdata;
         end
         if (inj && c == 1) begin
            Inicio    = 1'b1;
            Direccion = 32'h0000_0040;
            Tamano    = 2'b10;
         end
         @(posedge clk); #1;
         MemReady = 1'b0;
         MemRData = 32'h5A5A_5A5A;
         Inicio   = 1'b0;
      end
      chk("memreq_cycles", req_cycles, exp_req);
      chk("pulse_timing", {30'd0, Error, Valido}, exp_err ? 32'd2 : 32'd1);
   endtask

   initial begin
      rst       = 1'b1;
      Inicio    = 1'b0;
      Direccion = 32'h0000_0000;
      Tamano    = 2'b00;
      MemReady  = 1'b0;
      MemRData  = 32'h0000_0000;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", {Ocupado, MemReq, Valido, Error, 28'd0}, 32'd0);
      chk("reset_dato", Dato, 32'h0000_0000);
      chk("reset_memaddr", MemAddr, 32'h0000_0000);
      rst = 1'b0;

      do_load(32'h0000_1003, 2'b00, 0,  32'h80AA_BBCC, 1'b0, 32'h0000_0080, 1,  1'b0);
      do_load(32'h0000_2002, 2'b01, 3,  32'h1234_ABCD, 1'b0, 32'h0000_1234, 4,  1'b0);
      do_load(32'h0000_3001, 2'b10, 0,  32'h0000_0000, 1'b1, 32'h0000_0000, 0,  1'b0);
      do_load(32'h0000_3001, 2'b11, 0,  32'h0000_0000, 1'b1, 32'h0000_0000, 0,  1'b0);
      do_load(32'h0000_2001, 2'b01, 0,  32'h0000_0000, 1'b1, 32'h0000_0000, 0,  1'b0);
      do_load(32'h0000_5001, 2'b00, 1,  32'h80AA_BBCC, 1'b0, 32'h0000_00BB, 2,  1'b0);
      do_load(32'h0000_5002, 2'b00, 0,  32'h80AA_BBCC, 1'b0, 32'h0000_00AA, 1,  1'b0);
      do_load(32'h0000_5000, 2'b00, 0,  32'h80AA_BBCC, 1'b0, 32'h0000_00CC, 1,  1'b0);
      do_load(32'h0000_6000, 2'b01, 2,  32'h1234_ABCD, 1'b0, 32'h0000_ABCD, 3,  1'b0);
      do_load(32'h0000_7000, 2'b10, 0,  32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1,  1'b0);
      do_load(32'h0000_8000, 2'b00, 99, 32'h0000_0000, 1'b1, 32'h0000_0000, 16, 1'b0);
      do_load(32'h0000_9004, 2'b10, 15, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 16, 1'b0);
      do_load(32'h0000_A000, 2'b10, 3,  32'h0102_0304, 1'b0, 32'h0102_0304, 4,  1'b1);
      @(posedge clk); #1;
      chk("idle_after_inject", {31'd0, Ocupado}, 32'd0);

      // Reset in the middle of a request: everything clears at once, nothing completes.
      @(posedge clk); #1;
      Inicio    = 1'b1;
      Direccion = 32'h0000_C000;
      Tamano    = 2'b10;
      @(posedge clk); #1;
      Inicio = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("req_before_reset", {31'd0, MemReq}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_reset_ctrl", {Ocupado, MemReq, Valido, Error, 28'd0}, 32'd0);
      chk("async_reset_dato", Dato, 32'h0000_0000);
      chk("async_reset_byte", {24'd0, Byte}, 32'd0);
      chk("async_reset_addr", MemAddr, 32'h0000_0000);
      @(posedge clk); #1;
      rst       = 1'b0;
      last_dato = 32'h0000_0000;
      MemReady  = 1'b1;
      MemRData  = 32'hFFFF_FFFF;
      repeat (3) @(posedge clk);
      #1;
      MemReady = 1'b0;
      chk("ready_ignored_idle", {Ocupado, MemReq, 30'd0}, 32'd0);

      do_load(32'h0000_B001, 2'b00, 0,  32'h0000_FF00, 1'b0, 32'h0000_00FF, 1,  1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_drained", sb_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
